enigma_output_formatter: RTL and testbench

ENIGMA_OUTPUT_FORMATTER -- requirements
Module: enigma_output_formatter

---
 rtl/enigma_pkg.sv | 32 +++
 rtl/enigma_code_fifo.sv | 60 ++++++
 rtl/enigma_output_formatter.sv | 194 +++++++++++++++++++
 tb/tb_enigma_output_formatter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared definitions for the enigma output path: letter-code width, the
// alphabet size, the ASCII bytes the formatter emits and the formatter FSM
// state encoding.
package enigma_pkg;

  localparam int CODE_W   = 5;
  localparam int ALPHABET = 26;

  localparam logic [7:0] ASCII_A   = 8'h41;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_NUL = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LETTER = 3'd1,
    ST_SEP    = 3'd2,
    ST_CR     = 3'd3,
    ST_LF     = 3'd4
  } fmt_state_e;

  // Codes 26..31 do not map to a letter and are discarded on entry.
  function automatic logic code_is_legal(input logic [CODE_W-1:0] code);
    return code < CODE_W'(ALPHABET);
  endfunction

  // 0 -> 'A' ... 25 -> 'Z'.
  function automatic logic [7:0] code_to_ascii(input logic [CODE_W-1:0] code);
    return ASCII_A + {{(8 - CODE_W){1'b0}}, code};
  endfunction

endpackage

// File: rtl/enigma_code_fifo.sv
// Synchronous letter-code FIFO. Besides the usual full/empty flags it exposes
// the head entry and the entry behind it, so the formatter can present the
// next letter in the same cycle it retires the current one.
module enigma_code_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [WIDTH-1:0]           o_head,
  output logic [WIDTH-1:0]           o_head_next
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW-1:0]    w_rd_idx;
  logic [AW-1:0]    w_rd_idx_next;
  logic             w_push;
  logic             w_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_count       = r_wr_ptr - r_rd_ptr;
  assign o_full        = (o_count == DEPTH_L);
  assign o_empty       = (o_count == '0);
  assign w_push        = i_wr_en && !o_full;
  assign w_pop         = i_rd_en && !o_empty;
  assign w_rd_idx      = r_rd_ptr[AW-1:0];
  assign w_rd_idx_next = w_rd_idx + AW'(1);
  assign o_head        = r_mem[w_rd_idx];
  assign o_head_next   = r_mem[w_rd_idx_next];

  // Storage array: written at the tail, contents are not reset (pointers are).
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  // Pointer update; reset empties the FIFO and discards anything buffered.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/enigma_output_formatter.sv
// Turns the enigma core's letter codes into an ASCII stream: letters are
// grouped GROUP_LEN at a time with SEP_CHAR between groups, and a flush
// request closes the line with CR LF. Output handshake is valid/ready with
// registered out_char/out_valid.
module enigma_output_formatter
  import enigma_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter int         GROUP_LEN  = 5,
  parameter logic [7:0] SEP_CHAR   = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [7:0]        out_char,
  input  logic              out_ready,
  output logic              err_code,
  output logic [15:0]       letter_count
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int GCW     = $clog2(GROUP_LEN + 1);
  localparam logic [GCW-1:0]   GRP_FULL = GCW'(GROUP_LEN);
  localparam logic [FIFO_AW:0] TWO      = (FIFO_AW + 1)'(2);

  // Registered state
  fmt_state_e     r_state;
  logic [7:0]     r_out_char;
  logic [GCW-1:0] r_group_cnt;
  logic           r_flush_pending;
  logic           r_err_code;
  logic [15:0]    r_letter_count;
  logic           r_run;

  // Next-state and handshake wires
  fmt_state_e        w_state_next;
  logic [7:0]        w_char_next;
  logic [GCW-1:0]    w_grp_next;
  logic [GCW-1:0]    w_grp_inc;
  logic              w_flush_clear;
  logic              w_accept;
  logic              w_code_legal;
  logic              w_fifo_wr_en;
  logic              w_fifo_rd_en;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_fifo_has2;
  logic [FIFO_AW:0]  w_fifo_count;
  logic [CODE_W-1:0] w_fifo_head;
  logic [CODE_W-1:0] w_fifo_head_next;
  logic              w_letter_xfer;

  // r_run holds in_ready low during reset and releases it on the first clock.
  assign in_ready      = r_run && !w_fifo_full && !r_flush_pending;
  assign w_accept      = in_valid && in_ready;
  assign w_code_legal  = code_is_legal(in_code);
  assign w_fifo_wr_en  = w_accept && w_code_legal;
  assign w_fifo_has2   = (w_fifo_count >= TWO);
  assign w_grp_inc     = r_group_cnt + GCW'(1);
  assign w_letter_xfer = (r_state == ST_LETTER) && out_ready;

  assign out_valid    = (r_state != ST_IDLE);
  assign out_char     = r_out_char;
  assign err_code     = r_err_code;
  assign letter_count = r_letter_count;

  enigma_code_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk         (clk),
    .i_rst_n     (rst),
    .i_wr_en     (w_fifo_wr_en),
    .i_wr_data   (in_code),
    .i_rd_en     (w_fifo_rd_en),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count),
    .o_head      (w_fifo_head),
    .o_head_next (w_fifo_head_next)
  );

  // Output FSM. The displayed letter stays at the FIFO head until it is
  // transferred, so the FIFO plus output register never hold more than
  // FIFO_DEPTH codes. A separator is only chosen when a letter is waiting.
  always_comb begin
    w_state_next  = r_state;
    w_char_next   = r_out_char;
    w_grp_next    = r_group_cnt;
    w_fifo_rd_en  = 1'b0;
    w_flush_clear = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          if (r_group_cnt == GRP_FULL) begin
            w_state_next = ST_SEP;
            w_char_next  = SEP_CHAR;
          end else begin
            w_state_next = ST_LETTER;
            w_char_next  = code_to_ascii(w_fifo_head);
          end
        end else if (r_flush_pending) begin
          w_state_next = ST_CR;
          w_char_next  = ASCII_CR;
        end
      end
      ST_LETTER: begin
        if (out_ready) begin
          w_fifo_rd_en = 1'b1;
          w_grp_next   = w_grp_inc;
          if (w_fifo_has2) begin
            if (w_grp_inc == GRP_FULL) begin
              w_state_next = ST_SEP;
              w_char_next  = SEP_CHAR;
            end else begin
              w_state_next = ST_LETTER;
              w_char_next  = code_to_ascii(w_fifo_head_next);
            end
          end else begin
            w_state_next = ST_IDLE;
            w_char_next  = ASCII_NUL;
          end
        end
      end
      ST_SEP: begin
        if (out_ready) begin
          w_grp_next   = '0;
          w_state_next = ST_LETTER;
          w_char_next  = code_to_ascii(w_fifo_head);
        end
      end
      ST_CR: begin
        if (out_ready) begin
          w_state_next = ST_LF;
          w_char_next  = ASCII_LF;
        end
      end
      ST_LF: begin
        if (out_ready) begin
          w_state_next  = ST_IDLE;
          w_char_next   = ASCII_NUL;
          w_grp_next    = '0;
          w_flush_clear = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_char_next  = ASCII_NUL;
      end
    endcase
  end

  // FSM, output byte and group counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_out_char  <= ASCII_NUL;
      r_group_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_out_char  <= w_char_next;
      r_group_cnt <= w_grp_next;
    end
  end

  // Flush request latch; a request arriving while one is pending merges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flush_pending <= 1'b0;
    end else if (w_flush_clear) begin
      r_flush_pending <= 1'b0;
    end else if (flush) begin
      r_flush_pending <= 1'b1;
    end
  end

  // Sticky illegal-code flag, letter counter and post-reset run enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_code     <= 1'b0;
      r_letter_count <= 16'd0;
      r_run          <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_accept && !w_code_legal) r_err_code <= 1'b1;
      if (w_letter_xfer) r_letter_count <= r_letter_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_enigma_output_formatter.sv
// Scoreboard bench for enigma_output_formatter. The stimulus side predicts the
// output text from the formatting rules (letters, a separator before every
// GROUP_LEN+1-th letter of a line, CR LF per flush) and queues it; a separate
// monitor pops one byte per output transfer and compares.
module tb_enigma_output_formatter;
  import enigma_pkg::*;

  localparam int         FIFO_DEPTH = 8;
  localparam int         GROUP_LEN  = 5;
  localparam logic [7:0] SEP_CHAR   = 8'h20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  in_code = 5'd0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_char;
  logic        err_code;
  logic [15:0] letter_count;

  always #5 clk = ~clk;

  enigma_output_formatter #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .GROUP_LEN  (GROUP_LEN),
    .SEP_CHAR   (SEP_CHAR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_code      (in_code),
    .in_ready     (in_ready),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_char     (out_char),
    .out_ready    (out_ready),
    .err_code     (err_code),
    .letter_count (letter_count)
  );

  // Scoreboard and reference model state
  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          m_pending = 1'b0;
  bit          m_lf_done = 1'b0;
  bit          m_err = 1'b0;
  int          m_grp = 0;
  logic [15:0] m_letters = 16'd0;
  int          m_accepts = 0;
  int          ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
  bit          stall_prev = 1'b0;
  logic [7:0]  prev_char = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // One clock of stimulus: drive after the edge, evaluate the handshake at
  // mid-cycle, update the model, then move to just after the next edge.
  task automatic step(input logic v, input logic [4:0] c, input logic fl);
    bit         acc;
    bit         fl_taken;
    bit         pend_pre;
    logic [7:0] letter;
    in_valid = v;
    in_code  = c;
    flush    = fl;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 9) < 7);
    endcase
    @(negedge clk);
    #1;
    pend_pre = m_pending;
    if (pend_pre) check("in_ready_low_while_flush_pending", 32'(in_ready), 0);
    check("err_code", 32'(err_code), 32'(m_err));
    acc      = in_valid && in_ready;
    fl_taken = flush && !pend_pre;
    if (m_lf_done) begin
      m_pending = 1'b0;
      m_lf_done = 1'b0;
    end
    if (acc) begin
      m_accepts++;
      if (in_code < 5'd26) begin
        if (m_grp == GROUP_LEN) begin
          exp_q.push_back(SEP_CHAR);
          m_grp = 0;
        end
        letter = 8'h41 + {3'b000, in_code};
        exp_q.push_back(letter);
        m_grp++;
        m_letters++;
      end else begin
        m_err = 1'b1;
      end
    end
    if (fl_taken) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      m_grp     = 0;
      m_pending = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Run with out_ready high until the scoreboard is empty and the output has
  // stayed idle for a few cycles, then compare the letter counter.
  task automatic drain(input string tag);
    int quiet = 0;
    int n = 0;
    ready_mode = 1;
    while (quiet < 4 && n < 300) begin
      step(1'b0, 5'd0, 1'b0);
      n++;
      if (exp_q.size() == 0 && !out_valid) quiet++;
      else quiet = 0;
    end
    check({tag, "_drained"}, 32'(quiet >= 4), 1);
    check({tag, "_letter_count"}, 32'(letter_count), 32'(m_letters));
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_code   = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    m_pending = 1'b0;
    m_lf_done = 1'b0;
    m_err     = 1'b0;
    m_grp     = 0;
    m_letters = 16'd0;
    m_accepts = 0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_char", 32'(out_char), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_letter_count", 32'(letter_count), 0);
    rst = 1'b1;
    #1;
    check("in_ready_before_first_clock", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    check("in_ready_first_clock_after_reset", 32'(in_ready), 1);
  endtask

  // Monitor: one line per output transfer, compared against the queue head;
  // also checks that a stalled byte does not change.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (stall_prev) begin
          check("hold_out_valid", 32'(out_valid), 1);
          check("hold_out_char", 32'(out_char), 32'(prev_char));
        end
        if (out_valid && out_ready) begin
          $display("[%0t] out byte 0x%02h", $time, out_char);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: got %02h, required no output", out_char);
          end else begin
            e = exp_q.pop_front();
            check("out_char", 32'(out_char), 32'(e));
            if (e == 8'h0A) m_lf_done = 1'b1;
          end
        end
        stall_prev = out_valid && !out_ready;
        prev_char  = out_char;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // Watchdog: the run must end on its own.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  start;
    bit  found;
    bit  v;
    bit  fl;
    logic [4:0] c;
    #1;

    // A, B, Z with two-cycle latency from first accept to out_valid
    do_reset();
    ready_mode = 1;
    step(1'b1, 5'd0, 1'b0);
    check("latency_not_early", 32'(out_valid), 0);
    step(1'b1, 5'd1, 1'b0);
    check("latency_valid", 32'(out_valid), 1);
    check("latency_char_A", 32'(out_char), 32'h41);
    step(1'b1, 5'd25, 1'b0);
    drain("abz");

    // Twelve H then flush: two full groups, no trailing separator
    do_reset();
    ready_mode = 1;
    for (int i = 0; i < 12; i++) step(1'b1, 5'd7, 1'b0);
    step(1'b0, 5'd0, 1'b1);
    check("h12_accepts", 32'(m_accepts), 12);
    drain("h12");
    check("h12_letter_count", 32'(letter_count), 12);

    // Output stalled: FIFO_DEPTH accepts, then in_ready drops
    ready_mode = 0;
    start = m_accepts;
    for (int i = 0; i < 10; i++) step(1'b1, 5'(i + 3), 1'b0);
    check("full_accepts", 32'(m_accepts - start), FIFO_DEPTH);
    check("full_in_ready", 32'(in_ready), 0);
    drain("full");

    // Illegal code dropped between two letters
    do_reset();
    ready_mode = 1;
    step(1'b1, 5'd2, 1'b0);
    step(1'b1, 5'd27, 1'b0);
    step(1'b1, 5'd3, 1'b0);
    drain("illegal");
    check("illegal_err_sticky", 32'(err_code), 1);
    check("illegal_letter_count", 32'(letter_count), 2);

    // Flush with a same-cycle letter, merged flush during CR, empty flush
    ready_mode = 1;
    step(1'b1, 5'd4, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid && out_char == 8'h0D) found = 1'b1;
      else step(1'b0, 5'd0, 1'b0);
    end
    check("saw_cr", 32'(found), 1);
    ready_mode = 0;
    step(1'b0, 5'd0, 1'b1);
    step(1'b0, 5'd0, 1'b0);
    check("cr_held", 32'(out_char), 32'h0D);
    drain("flush_merge");
    step(1'b0, 5'd0, 1'b1);
    drain("flush_empty");
    check("err_still_set", 32'(err_code), 1);

    // Randomized traffic with random back-pressure and occasional flushes
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 9) < 6);
      c  = ($urandom_range(0, 7) == 0) ? 5'(26 + $urandom_range(0, 5))
                                        : 5'($urandom_range(0, 25));
      fl = ($urandom_range(0, 29) == 0);
      step(v, c, fl);
    end
    drain("random");

    // Reset while a byte is stalled with codes queued
    ready_mode = 0;
    step(1'b1, 5'd10, 1'b0);
    step(1'b1, 5'd11, 1'b0);
    step(1'b1, 5'd12, 1'b0);
    step(1'b0, 5'd0, 1'b0);
    check("prereset_stalled", 32'(out_valid), 1);
    rst = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 0);
    check("async_rst_out_char", 32'(out_char), 0);
    check("async_rst_in_ready", 32'(in_ready), 0);
    do_reset();
    drain("post_reset");
    check("post_reset_letter_count", 32'(letter_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
